// File: rtl/gray_step_checker.sv
// Passive monitor for a 3-bit Gray-code counter: verifies single forward steps,
// counts steps and wraps, and latches the first illegal transition as a sticky error.
module gray_step_checker #(
    parameter int unsigned CNT_W  = 8,
    parameter int unsigned WRAP_W = 4
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              En,
    input  logic              Clear,
    input  logic [2:0]        Gray,
    input  logic              Ovf_in,
    output logic [2:0]        Bin,
    output logic              Step,
    output logic [CNT_W-1:0]  Steps,
    output logic [WRAP_W-1:0] Wraps,
    output logic              Err,
    output logic [1:0]        Err_code
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        ERROR = 2'd2
    } state_t;

    localparam logic [1:0] CODE_NONE  = 2'b00;
    localparam logic [1:0] CODE_MULTI = 2'b01;
    localparam logic [1:0] CODE_BACK  = 2'b10;
    localparam logic [1:0] CODE_OVF   = 2'b11;

    state_t              state_q, state_d;
    logic [2:0]          prev_q, prev_d;
    logic                prev_ovf_q, prev_ovf_d;
    logic [2:0]          bin_q, bin_d;
    logic                step_q, step_d;
    logic [CNT_W-1:0]    steps_q, steps_d;
    logic [WRAP_W-1:0]   wraps_q, wraps_d;
    logic                err_q, err_d;
    logic [1:0]          err_code_q, err_code_d;

    logic [2:0] gray_bin;
    logic [2:0] prev_bin;
    logic [2:0] delta;
    logic [2:0] diff;
    logic [2:0] diff_m1;
    logic       changed;
    logic       one_bit;
    logic       fwd;
    logic       bwd;
    logic       is_wrap;
    logic       ovf_rise;
    logic       ovf_bad;
    logic [1:0] cause;

    function automatic logic [2:0] gray2bin(input logic [2:0] g);
        logic [2:0] b;
        b[2] = g[2];
        b[1] = g[2] ^ g[1];
        b[0] = b[1] ^ g[0];
        return b;
    endfunction

    // Classify the incoming sample against the stored previous sample.
    always_comb begin
        gray_bin = gray2bin(Gray);
        prev_bin = gray2bin(prev_q);
        delta    = gray_bin - prev_bin;
        diff     = Gray ^ prev_q;
        diff_m1  = diff - 3'd1;
        changed  = (diff != 3'd0);
        one_bit  = changed && ((diff & diff_m1) == 3'd0);
        fwd      = one_bit && (delta == 3'd1);
        bwd      = one_bit && (delta == 3'd7);
        is_wrap  = fwd && (prev_bin == 3'd7);
        ovf_rise = !prev_ovf_q && Ovf_in;
        ovf_bad  = is_wrap ? !Ovf_in : ovf_rise;

        // A change that is neither a single forward nor backward step is a jump.
        if (changed && !(fwd || bwd)) begin
            cause = CODE_MULTI;
        end else if (bwd) begin
            cause = CODE_BACK;
        end else if (ovf_bad) begin
            cause = CODE_OVF;
        end else begin
            cause = CODE_NONE;
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_d    = state_q;
        prev_d     = prev_q;
        prev_ovf_d = prev_ovf_q;
        bin_d      = bin_q;
        step_d     = 1'b0;
        steps_d    = steps_q;
        wraps_d    = wraps_q;
        err_d      = err_q;
        err_code_d = err_code_q;

        if (Clear) begin
            state_d    = IDLE;
            prev_d     = 3'd0;
            prev_ovf_d = 1'b0;
            bin_d      = 3'd0;
            steps_d    = '0;
            wraps_d    = '0;
            err_d      = 1'b0;
            err_code_d = CODE_NONE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (En) begin
                        prev_d     = Gray;
                        prev_ovf_d = Ovf_in;
                        bin_d      = gray_bin;
                        state_d    = TRACK;
                    end
                end
                TRACK: begin
                    if (En) begin
                        if (cause != CODE_NONE) begin
                            err_d      = 1'b1;
                            err_code_d = cause;
                            state_d    = ERROR;
                        end else begin
                            prev_ovf_d = Ovf_in;
                            if (fwd) begin
                                prev_d  = Gray;
                                bin_d   = gray_bin;
                                step_d  = 1'b1;
                                steps_d = steps_q + CNT_W'(1);
                                if (is_wrap && (wraps_q != {WRAP_W{1'b1}})) begin
                                    wraps_d = wraps_q + WRAP_W'(1);
                                end
                            end
                        end
                    end
                end
                ERROR: begin
                    err_d = 1'b1;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= IDLE;
            prev_q     <= 3'd0;
            prev_ovf_q <= 1'b0;
            bin_q      <= 3'd0;
            step_q     <= 1'b0;
            steps_q    <= '0;
            wraps_q    <= '0;
            err_q      <= 1'b0;
            err_code_q <= CODE_NONE;
        end else begin
            state_q    <= state_d;
            prev_q     <= prev_d;
            prev_ovf_q <= prev_ovf_d;
            bin_q      <= bin_d;
            step_q     <= step_d;
            steps_q    <= steps_d;
            wraps_q    <= wraps_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

    assign Bin      = bin_q;
    assign Step     = step_q;
    assign Steps    = steps_q;
    assign Wraps    = wraps_q;
    assign Err      = err_q;
    assign Err_code = err_code_q;

endmodule

// File: doc/gray_step_checker.md
# gray_step_checker

Downstream monitor for the 3-bit Gray-code counter. Samples the counter's `Output`/`Overflow` pair whenever `En` is high and decodes the code to binary. It checks that every change is a legal single forward Gray step, accumulates step and wrap counts, and latches a sticky error with a cause code on the first illegal transition. All outputs are registered; the block only observes and never drives the counter.

## Interface
Parameters:
- `CNT_W`, default 8: width of the forward-step counter, which counts modulo 2^CNT_W.
- `WRAP_W`, default 4: width of the wrap counter, which saturates at all-ones.

Ports:
- `Clk` input 1: single clock, rising edge.
- `Reset_n` input 1: asynchronous, active-low reset.
- `En` input 1: sample strobe. `Gray` and `Ovf_in` are captured on a rising `Clk` edge where `En=1`.
- `Clear` input 1: synchronous restart. Returns the block to `IDLE` and zeroes all counters and flags.
- `Gray` input 3: Gray code from the upstream counter.
- `Ovf_in` input 1: upstream sticky Overflow flag.
- `Bin` output 3: binary decode of the last accepted sample.
- `Step` output 1: one-cycle pulse when a legal forward step is accepted.
- `Steps` output CNT_W: total legal forward steps accepted.
- `Wraps` output WRAP_W: number of 7→0 steps seen, saturating.
- `Err` output 1: sticky error flag.
- `Err_code` output 2: cause of the first error. 00 none, 01 multi-bit change, 10 backward single-bit step, 11 overflow mismatch.

## Operation
- Decode rule: `Bin[2]=Gray[2]`, `Bin[1]=Gray[2]^Gray[1]`, `Bin[0]=Bin[1]^Gray[0]`.
- FSM states: `IDLE`, `TRACK`, `ERROR`.
- Reset (`Reset_n=0`, asynchronous): state `IDLE`. `Bin=0`, `Step=0`, `Steps=0`, `Wraps=0`, `Err=0`, `Err_code=00`, stored previous sample `prev=000`, `prev_ovf=0`.
- `IDLE`: the first sample with `En=1` loads `prev`, `prev_ovf` and `Bin`. No step is counted and no check is made. Next state is `TRACK`.
- `TRACK`, on each sample, with `d = Bin(Gray) - Bin(prev)` taken mod 8:
  - `Gray == prev`: hold. No step, no error. `prev_ovf` updates.
  - One bit differs and `d == 1`: legal step. Pulse `Step`, increment `Steps` (wraps mod 2^CNT_W), update `Bin`/`prev`/`prev_ovf`.
    - If `Bin(prev)==7`, the step is a wrap: increment `Wraps` (saturating), and `Ovf_in` must be 1, otherwise the error is code 11.
  - One bit differs and `d == 7`: backward step. Error code 10.
  - Two or more bits differ: error code 01.
  - `Ovf_in` rises (`prev_ovf=0`, `Ovf_in=1`) on a sample that is not a wrap: error code 11.
  - When the multi-bit check and the overflow check fail together, code 01 takes priority over 11.
- `ERROR`: `Err=1`, and `Err_code` is frozen at the first cause. `Bin`, `Steps` and `Wraps` are frozen, and samples are ignored.
- `Clear=1` in any state: the next edge yields the reset values and state `IDLE`. `Clear` takes priority over a simultaneous `En` sample, which is discarded.
- `Ovf_in` staying at 1 across later wraps is legal.

## Timing
- All outputs change only on a rising `Clk` edge, except on asynchronous reset assertion.
- Latency from a sample edge to `Bin`/`Steps`/`Wraps`/`Err` updates is 1 cycle. `Step` is high for exactly that one cycle.
- An error is flagged on the same edge as the offending sample is taken. On that edge `Step=0` and counters do not change.
- Back-to-back samples (`En` held high) are supported at full rate with no bubbles.
- `Reset_n` deassertion takes effect from the first following edge.

## Test plan
1. Reset, then `En=1` for 9 cycles feeding 000,001,011,010,110,111,101,100,000 with `Ovf_in` rising with the final 000 → `Steps=8`, `Wraps=1`, `Bin=0`, `Err=0`, and 8 `Step` pulses.
2. Samples 000 then 011 → `Err=1`, `Err_code=01`, `Steps=0`. Later samples leave `Bin=0` unchanged.
3. Samples 011 then 001 → `Err_code=10`, `Bin=2` is held.
4. Samples 000, 001 with `Ovf_in=1` on the second sample → `Err_code=11`. Also: a full cycle ending 100→000 with `Ovf_in=0` → `Err_code=11`, and `Wraps` is not incremented.
5. Enter `ERROR`, then `Clear=1` together with `En=1, Gray=001` → next cycle state is `IDLE`, all outputs are 0, and the sample is discarded. The next sample `001` is accepted as a baseline: `Bin=1`, `Steps=0`.
6. With `En=1`, sweep 16 wraps and `WRAP_W=4` → `Wraps` saturates at 15 and `Steps=128`. Assert `Reset_n=0` mid-sweep → outputs clear immediately, without waiting for a clock edge.
